// File: rtl/vending_credit_ctrl.sv
// Credit and dispense sequencer: edge-detects coins, accumulates nickel credit,
// handshakes with the dispenser and pays change one nickel every other cycle.
module vending_credit_ctrl #(
   parameter int unsigned PRICE      = 3,
   parameter int unsigned MAX_CREDIT = 6,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [1:0] coin_i,
   input  logic       cancel_i,
   input  logic       disp_ack_i,
   output logic       disp_req_o,
   output logic       change_nickel_o,
   output logic       coin_reject_o,
   output logic [3:0] credit_o,
   output logic       busy_o,
   output logic [1:0] state_o
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_CREDIT   = 2'd1;
   localparam logic [1:0] S_DISPENSE = 2'd2;
   localparam logic [1:0] S_CHANGE   = 2'd3;

   // The counter only needs to hold 0..TIMEOUT-1; expiry fires on the last value.
   localparam int unsigned    CW       = $clog2(TIMEOUT);
   localparam logic [CW-1:0]  TMO_LAST = CW'(TIMEOUT - 1);
   localparam logic [3:0]     PRICE_C  = 4'(PRICE);
   localparam logic [4:0]     PRICE_W  = 5'(PRICE);
   localparam logic [4:0]     MAX_W    = 5'(MAX_CREDIT);

   logic [1:0]    state_q, state_d;
   logic [3:0]    credit_q, credit_d;
   logic [1:0]    coin_prev_q;
   logic [CW-1:0] idle_cnt_q, idle_cnt_d;
   logic          nickel_q, nickel_d;
   logic          reject_q, reject_d;

   logic          coin_evt;
   logic          coin_ok;
   logic [1:0]    coin_val;
   logic [4:0]    credit_sum;
   logic          accept;

   always_comb begin
      coin_evt = (coin_i != 2'b00) && (coin_prev_q == 2'b00);
      coin_val = 2'd0;
      coin_ok  = 1'b0;
      case (coin_i)
         2'b01:   begin coin_val = 2'd1; coin_ok = 1'b1; end
         2'b10:   begin coin_val = 2'd2; coin_ok = 1'b1; end
         default: ;
      endcase
      credit_sum = {1'b0, credit_q} + {3'b000, coin_val};
      // A cancel in CREDIT takes priority, so a coin arriving with it is refused.
      accept = coin_evt && coin_ok && (credit_sum <= MAX_W) &&
               ((state_q == S_IDLE) || ((state_q == S_CREDIT) && !cancel_i));
   end

   always_comb begin
      state_d    = state_q;
      credit_d   = credit_q;
      idle_cnt_d = '0;
      nickel_d   = 1'b0;
      reject_d   = coin_evt && !accept;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               credit_d = credit_sum[3:0];
               state_d  = (credit_sum >= PRICE_W) ? S_DISPENSE : S_CREDIT;
            end
         end
         S_CREDIT: begin
            if (cancel_i) begin
               state_d  = S_CHANGE;
               nickel_d = 1'b1;
            end else if (accept) begin
               credit_d = credit_sum[3:0];
               state_d  = (credit_sum >= PRICE_W) ? S_DISPENSE : S_CREDIT;
            end else if (idle_cnt_q == TMO_LAST) begin
               state_d  = S_CHANGE;
               nickel_d = 1'b1;
            end else begin
               idle_cnt_d = idle_cnt_q + CW'(1);
            end
         end
         S_DISPENSE: begin
            if (disp_ack_i) begin
               credit_d = credit_q - PRICE_C;
               if (credit_q > PRICE_C) begin
                  state_d  = S_CHANGE;
                  nickel_d = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_CHANGE: begin
            // Pulse high, then low; credit drops at the edge closing each high cycle.
            if (nickel_q) begin
               credit_d = credit_q - 4'd1;
               if (credit_q == 4'd1) state_d = S_IDLE;
            end else begin
               nickel_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         credit_q    <= 4'd0;
         coin_prev_q <= 2'b00;
         idle_cnt_q  <= '0;
         nickel_q    <= 1'b0;
         reject_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         credit_q    <= credit_d;
         coin_prev_q <= coin_i;
         idle_cnt_q  <= idle_cnt_d;
         nickel_q    <= nickel_d;
         reject_q    <= reject_d;
      end
   end

   assign disp_req_o      = (state_q == S_DISPENSE);
   assign busy_o          = (state_q == S_DISPENSE) || (state_q == S_CHANGE);
   assign change_nickel_o = nickel_q;
   assign coin_reject_o   = reject_q;
   assign credit_o        = credit_q;
   assign state_o         = state_q;

endmodule
